// File: rtl/sram_arbiter_pkg.sv
// Shared widths, FSM encoding and command type for sram_arbiter.
package sram_arbiter_pkg;

    localparam int unsigned ADDR_W           = 16;
    localparam int unsigned DATA_W           = 16;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_cmd_t;

endpackage

// File: rtl/arb_req_latch.sv
// Per-requester command register with pending flag and sticky overrun detect.
module arb_req_latch
    import sram_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_grant,
    output logic              o_pending,
    output mem_cmd_t          o_cmd,
    output logic              o_overrun
);

    logic     r_pending;
    mem_cmd_t r_cmd;
    logic     r_overrun;
    logic     w_accept;

    // A grant empties the slot on the same edge, so a coinciding start is accepted.
    assign w_accept = i_start && (!r_pending || i_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_cmd     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pending <= 1'b1;
                r_cmd     <= {i_rw, i_addr, i_data};
            end else if (i_grant) begin
                r_pending <= 1'b0;
            end
            if (i_start && !w_accept) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_cmd     = r_cmd;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM command arbiter, fixed A priority.
// Optional B starvation guard enabled by defining SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_a,
    input  logic              rw_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              ready_a,
    input  logic              start_b,
    input  logic              rw_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              ready_b,
    output logic [DATA_W-1:0] rdata_out,
    output logic              mem_start,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        overrun
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       w_pend_a;
    logic       w_pend_b;
    mem_cmd_t   w_cmd_a;
    mem_cmd_t   w_cmd_b;
    logic       w_ovr_a;
    logic       w_ovr_b;
    logic       w_grant_a;
    logic       w_grant_b;
    logic       w_b_first;
    logic       r_win_b;
    mem_cmd_t   r_mem_cmd;
    logic [DATA_W-1:0] r_rdata;

    arb_req_latch u_req_a (
        .clk       (clk),
        .reset     (reset),
        .i_start   (start_a),
        .i_rw      (rw_a),
        .i_addr    (addr_a),
        .i_data    (data_a),
        .i_grant   (w_grant_a),
        .o_pending (w_pend_a),
        .o_cmd     (w_cmd_a),
        .o_overrun (w_ovr_a)
    );

    arb_req_latch u_req_b (
        .clk       (clk),
        .reset     (reset),
        .i_start   (start_b),
        .i_rw      (rw_b),
        .i_addr    (addr_b),
        .i_data    (data_b),
        .i_grant   (w_grant_b),
        .o_pending (w_pend_b),
        .o_cmd     (w_cmd_b),
        .o_overrun (w_ovr_b)
    );

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1) + 1;
    logic [CNT_W-1:0] r_starve_cnt;

    // Counts A wins over a waiting B; once at the limit B takes the next decision.
    assign w_b_first = (r_starve_cnt >= CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_grant_b) begin
            r_starve_cnt <= '0;
        end else if (w_grant_a && w_pend_b) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_b_first = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        mem_start = 1'b0;
        ready_a   = 1'b0;
        ready_b   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend_b && (!w_pend_a || w_b_first)) begin
                    w_grant_b = 1'b1;
                    w_next    = ST_ISSUE;
                end else if (w_pend_a) begin
                    w_grant_a = 1'b1;
                    w_next    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_start = 1'b1;
                w_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                ready_a = !r_win_b;
                ready_b = r_win_b;
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_b   <= 1'b0;
            r_mem_cmd <= '0;
            r_rdata   <= '0;
        end else begin
            if (w_grant_a || w_grant_b) begin
                r_win_b   <= w_grant_b;
                r_mem_cmd <= w_grant_b ? w_cmd_b : w_cmd_a;
            end
            if ((r_state == ST_WAIT) && mem_ready && !r_mem_cmd.rw) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign mem_rw    = r_mem_cmd.rw;
    assign mem_addr  = r_mem_cmd.addr;
    assign mem_wdata = r_mem_cmd.data;
    assign rdata_out = r_rdata;
    assign overrun   = {w_ovr_b, w_ovr_a};

endmodule
